// File: rtl/sr_bank_pkg.sv
// Shared types and helpers for the SR flag bank: conflict-policy enum, select width, next-state rule.
package sr_bank_pkg;

   typedef enum logic [1:0] {
      SR_SET_DOM = 2'd0,
      SR_RST_DOM = 2'd1,
      SR_HOLD    = 2'd2,
      SR_TOGGLE  = 2'd3
   } sr_mode_e;

   // Counter-select width; a single channel still gets a 1-bit select.
   function automatic int sel_width(input int ch);
      return (ch > 1) ? $clog2(ch) : 1;
   endfunction

   function automatic logic sr_next(input logic q, input logic s, input logic r,
                                    input sr_mode_e mode);
      logic n;
      n = q;
      if (s && !r) begin
         n = 1'b1;
      end else if (!s && r) begin
         n = 1'b0;
      end else if (s && r) begin
         case (mode)
            SR_SET_DOM: n = 1'b1;
            SR_RST_DOM: n = 1'b0;
            SR_HOLD:    n = q;
            SR_TOGGLE:  n = ~q;
            default:    n = q;
         endcase
      end
      return n;
   endfunction

endpackage

// File: rtl/sr_bank_if.sv
// Control/status bundle of the SR flag bank; master drives requests, slave is the bank.
interface sr_bank_if
   import sr_bank_pkg::*;
#(
   parameter int CH    = 8,
   parameter int CNT_W = 4
);
   localparam int SW = sel_width(CH);

   logic [CH-1:0]    en;
   logic [CH-1:0]    s;
   logic [CH-1:0]    r;
   logic [CH-1:0]    q;
   logic [CH-1:0]    qbar;
   logic [CH-1:0]    rise;
   logic [CH-1:0]    fall;
   logic [CH-1:0]    conflict;
   logic [CH-1:0]    conflict_clr;
   logic [SW-1:0]    cnt_sel;
   logic [CH-1:0]    cnt_clr;
   logic [CNT_W-1:0] cnt_out;

   modport master (
      output en, s, r, conflict_clr, cnt_sel, cnt_clr,
      input  q, qbar, rise, fall, conflict, cnt_out
   );

   modport slave (
      input  en, s, r, conflict_clr, cnt_sel, cnt_clr,
      output q, qbar, rise, fall, conflict, cnt_out
   );

endinterface

// File: rtl/sr_bank_cell.sv
// One SR channel: stored bit, registered rise/fall pulses, sticky conflict flag and,
// with SR_BANK_CNT_EN, a saturating rise counter. All state updates on one edge.
module sr_bank_cell
   import sr_bank_pkg::*;
#(
   parameter sr_mode_e MODE    = SR_SET_DOM,
   parameter logic     RST_BIT = 1'b0,
   parameter int       CNT_W   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             s,
   input  logic             r,
   input  logic             conflict_clr,
   input  logic             cnt_clr,
   output logic             q,
   output logic             rise,
   output logic             fall,
   output logic             conflict,
   output logic [CNT_W-1:0] cnt
);

   logic qn;
   logic rise_ev;
   logic fall_ev;

   assign qn      = en ? sr_next(q, s, r, MODE) : q;
   assign rise_ev = ~q & qn;
   assign fall_ev = q & ~qn;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q        <= RST_BIT;
         rise     <= 1'b0;
         fall     <= 1'b0;
         conflict <= 1'b0;
      end else begin
         q        <= qn;
         rise     <= rise_ev;
         fall     <= fall_ev;
         // A new conflict on the same edge as a clear must survive.
         conflict <= (en & s & r) | (conflict & ~conflict_clr);
      end
   end

`ifdef SR_BANK_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (cnt_clr) begin
         cnt <= rise_ev ? CNT_W'(1) : '0;
      end else if (rise_ev && (cnt != '1)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end
`else
   logic cnt_clr_unused;
   assign cnt_clr_unused = cnt_clr;
   assign cnt            = '0;
`endif

endmodule

// File: rtl/sr_bank.sv
// Bank of CH independent SR flag cells with selectable S&R policy; counters exist only
// when SR_BANK_CNT_EN is defined. Top level adds the combinational counter read mux.
module sr_bank
   import sr_bank_pkg::*;
#(
   parameter int            CH      = 8,
   parameter int            MODE    = 0,
   parameter logic [CH-1:0] RST_VAL = '0,
   parameter int            CNT_W   = 4
) (
   input  logic     clk,
   input  logic     reset,
   sr_bank_if.slave bus
);

   localparam int       SW     = sel_width(CH);
   localparam sr_mode_e MODE_E = sr_mode_e'(MODE[1:0]);

   logic [CH-1:0]    q;
   logic [CH-1:0]    rise;
   logic [CH-1:0]    fall;
   logic [CH-1:0]    conflict;
   logic [CNT_W-1:0] cnt [CH];
   logic [CNT_W-1:0] cnt_mux;

   for (genvar i = 0; i < CH; i++) begin : g_cell
      sr_bank_cell #(
         .MODE    (MODE_E),
         .RST_BIT (RST_VAL[i]),
         .CNT_W   (CNT_W)
      ) u_cell (
         .clk          (clk),
         .reset        (reset),
         .en           (bus.en[i]),
         .s            (bus.s[i]),
         .r            (bus.r[i]),
         .conflict_clr (bus.conflict_clr[i]),
         .cnt_clr      (bus.cnt_clr[i]),
         .q            (q[i]),
         .rise         (rise[i]),
         .fall         (fall[i]),
         .conflict     (conflict[i]),
         .cnt          (cnt[i])
      );
   end

   // Selects with no matching channel (>= CH) fall through to zero.
   always_comb begin
      cnt_mux = '0;
      for (int i = 0; i < CH; i++) begin
         if (bus.cnt_sel == i[SW-1:0]) begin
            cnt_mux = cnt[i];
         end
      end
   end

   assign bus.q        = q;
   assign bus.qbar     = ~q;
   assign bus.rise     = rise;
   assign bus.fall     = fall;
   assign bus.conflict = conflict;
   assign bus.cnt_out  = cnt_mux;

endmodule

// File: tb/tb_sr_bank.sv
// Drives four sr_bank instances (MODE 0..3) with shared stimulus and checks them against a scoreboard model.
`timescale 1ns/1ps
module tb_sr_bank;

   localparam int         CH    = 8;
   localparam int         CNT_W = 4;
   localparam logic [7:0] RV    = 8'hA5;
`ifdef SR_BANK_CNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] en, s, r, cclr, kclr;
   logic [2:0] sel;

   logic [7:0] q_m  [4];
   logic [7:0] qb_m [4];
   logic [7:0] ri_m [4];
   logic [7:0] fa_m [4];
   logic [7:0] cf_m [4];
   logic [3:0] co_m [4];

   always #5 clk = ~clk;

   for (genvar m = 0; m < 4; m++) begin : g_dut
      sr_bank_if #(.CH(CH), .CNT_W(CNT_W)) b ();
      assign b.en           = en;
      assign b.s            = s;
      assign b.r            = r;
      assign b.conflict_clr = cclr;
      assign b.cnt_clr      = kclr;
      assign b.cnt_sel      = sel;
      assign q_m[m]  = b.q;
      assign qb_m[m] = b.qbar;
      assign ri_m[m] = b.rise;
      assign fa_m[m] = b.fall;
      assign cf_m[m] = b.conflict;
      assign co_m[m] = b.cnt_out;
      sr_bank #(.CH(CH), .MODE(m), .RST_VAL(RV), .CNT_W(CNT_W)) dut (
         .clk   (clk),
         .reset (reset),
         .bus   (b)
      );
   end

   typedef struct {
      string      tag;
      logic [7:0] q  [4];
      logic [7:0] ri [4];
      logic [7:0] fa [4];
      logic [7:0] cf [4];
      logic [3:0] co [4];
   } exp_t;

   exp_t       sb [$];
   logic [7:0] mq  [4];
   logic [7:0] mcf [4];
   logic [3:0] mcnt [4][8];
   int         errors = 0;
   int         checks = 0;

   function automatic logic ref_bit(input int mode, input logic qv, input logic sv, input logic rv);
      case ({sv, rv})
         2'b10:   return 1'b1;
         2'b01:   return 1'b0;
         2'b00:   return qv;
         default: begin
            case (mode)
               0:       return 1'b1;
               1:       return 1'b0;
               2:       return qv;
               default: return ~qv;
            endcase
         end
      endcase
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 4; m++) begin
         mq[m]  = RV;
         mcf[m] = 8'h00;
         for (int i = 0; i < 8; i++) mcnt[m][i] = 4'd0;
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step(input string tag, input logic [7:0] en_i, input logic [7:0] s_i,
                       input logic [7:0] r_i, input logic [7:0] cclr_i, input logic [7:0] kclr_i);
      exp_t e;
      exp_t g;
      logic nq;
      en = en_i; s = s_i; r = r_i; cclr = cclr_i; kclr = kclr_i;
      e.tag = tag;
      for (int m = 0; m < 4; m++) begin
         for (int i = 0; i < 8; i++) begin
            nq = en_i[i] ? ref_bit(m, mq[m][i], s_i[i], r_i[i]) : mq[m][i];
            e.ri[m][i] = !mq[m][i] && nq;
            e.fa[m][i] = mq[m][i] && !nq;
            e.q[m][i]  = nq;
            e.cf[m][i] = (en_i[i] && s_i[i] && r_i[i]) || (mcf[m][i] && !cclr_i[i]);
            if (kclr_i[i])
               mcnt[m][i] = e.ri[m][i] ? 4'd1 : 4'd0;
            else if (e.ri[m][i] && mcnt[m][i] != 4'd15)
               mcnt[m][i] = mcnt[m][i] + 4'd1;
         end
         mq[m]  = e.q[m];
         mcf[m] = e.cf[m];
         e.co[m] = CNT_ON ? mcnt[m][sel] : 4'd0;
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      g = sb.pop_front();
      for (int m = 0; m < 4; m++) begin
         chk($sformatf("%s m%0d q", g.tag, m), q_m[m], g.q[m]);
         chk($sformatf("%s m%0d qbar", g.tag, m), qb_m[m], ~g.q[m]);
         chk($sformatf("%s m%0d rise", g.tag, m), ri_m[m], g.ri[m]);
         chk($sformatf("%s m%0d fall", g.tag, m), fa_m[m], g.fa[m]);
         chk($sformatf("%s m%0d conflict", g.tag, m), cf_m[m], g.cf[m]);
         chk($sformatf("%s m%0d cnt", g.tag, m), {4'd0, co_m[m]}, {4'd0, g.co[m]});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      en = 8'h00; s = 8'h00; r = 8'h00; cclr = 8'h00; kclr = 8'h00; sel = 3'd2;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      for (int m = 0; m < 4; m++) begin
         chk($sformatf("rst m%0d q", m), q_m[m], 8'hA5);
         chk($sformatf("rst m%0d qbar", m), qb_m[m], 8'h5A);
         chk($sformatf("rst m%0d rise", m), ri_m[m], 8'h00);
         chk($sformatf("rst m%0d fall", m), fa_m[m], 8'h00);
         chk($sformatf("rst m%0d conflict", m), cf_m[m], 8'h00);
      end
      reset = 1'b0;

      step("idle", 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);
      step("clr0", 8'hFF, 8'h00, 8'h01, 8'h00, 8'h00);
      step("set0", 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00);
      chk("set0 rise", ri_m[0], 8'h01);
      step("set0_hold", 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);
      chk("set0 pulse ends", ri_m[0], 8'h00);
      step("set0_again", 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00);
      chk("reset no rise", ri_m[0], 8'h00);

      step("conf", 8'hFF, 8'h01, 8'h01, 8'h00, 8'h00);
      chk("conf m0 q", q_m[0], 8'hA5);
      chk("conf m1 q", q_m[1], 8'hA4);
      chk("conf m1 fall", fa_m[1], 8'h01);
      chk("conf m2 q", q_m[2], 8'hA5);
      chk("conf m3 q", q_m[3], 8'hA4);
      for (int m = 0; m < 4; m++) chk($sformatf("conf m%0d flag", m), cf_m[m], 8'h01);

      step("cclr", 8'hFF, 8'h00, 8'h00, 8'h01, 8'h00);
      chk("cclr m0", cf_m[0], 8'h00);
      step("conf2", 8'hFF, 8'h01, 8'h01, 8'h00, 8'h00);
      step("cclr_conf", 8'hFF, 8'h01, 8'h01, 8'h01, 8'h00);
      for (int m = 0; m < 4; m++) chk($sformatf("set wins m%0d", m), cf_m[m], 8'h01);
      step("cclr2", 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00);

      step("dis3", 8'hF7, 8'h08, 8'h00, 8'h00, 8'h00);
      for (int m = 0; m < 4; m++) begin
         chk($sformatf("dis3 m%0d q3", m), q_m[m] & 8'h08, 8'h00);
         chk($sformatf("dis3 m%0d rise3", m), ri_m[m] & 8'h08, 8'h00);
      end
      step("dis3_sr", 8'hF7, 8'h08, 8'h08, 8'h00, 8'h00);
      for (int m = 0; m < 4; m++) chk($sformatf("dis3 m%0d conflict", m), cf_m[m], 8'h00);

      step("multi", 8'hFF, 8'hF0, 8'h0F, 8'h00, 8'h00);
      step("multi_sr", 8'hFF, 8'h3C, 8'h66, 8'h00, 8'h00);

      for (int k = 0; k < 20; k++) begin
         step("cnt_set", 8'hFF, 8'h04, 8'h00, 8'h00, 8'h00);
         step("cnt_rst", 8'hFF, 8'h00, 8'h04, 8'h00, 8'h00);
      end
      for (int m = 0; m < 4; m++) chk($sformatf("cnt sat m%0d", m), {4'd0, co_m[m]}, CNT_ON ? 8'd15 : 8'd0);
      step("cnt_clr_rise", 8'hFF, 8'h04, 8'h00, 8'h00, 8'h04);
      for (int m = 0; m < 4; m++) chk($sformatf("cnt clr+rise m%0d", m), {4'd0, co_m[m]}, CNT_ON ? 8'd1 : 8'd0);
      step("cnt_rst2", 8'hFF, 8'h00, 8'h04, 8'h00, 8'h00);
      step("cnt_set2", 8'hFF, 8'h04, 8'h00, 8'h00, 8'h00);

      for (int k = 0; k < 40; k++) begin
         sel = 3'($urandom_range(0, 7));
         step("rnd", 8'($urandom), 8'($urandom), 8'($urandom),
              8'($urandom) & 8'h55, 8'($urandom) & 8'h11);
      end

      sel = 3'd2;
      step("pre_arst", 8'hFF, 8'h01, 8'h01, 8'h00, 8'h00);
      #3;
      reset = 1'b1;
      #1;
      model_reset();
      for (int m = 0; m < 4; m++) begin
         chk($sformatf("arst m%0d q", m), q_m[m], 8'hA5);
         chk($sformatf("arst m%0d rise", m), ri_m[m], 8'h00);
         chk($sformatf("arst m%0d conflict", m), cf_m[m], 8'h00);
         chk($sformatf("arst m%0d cnt", m), {4'd0, co_m[m]}, 8'd0);
      end
      @(posedge clk);
      #2;
      reset = 1'b0;
      step("post_arst", 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);
      step("post_arst_set", 8'hFF, 8'h5A, 8'h00, 8'h00, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
